apb_slave_router: RTL and testbench

- Single-master to NUM_SLAVES APB4 decoder/router that sits between the core-side APB arbiter output and the peripheral slaves.
- Selects a slave from a fixed address-index field and forwards one transfer at a time.
- Answers unmapped addresses with an error response.
- Aborts transfers to slaves that never raise pready, using a per-transfer timeout, so the bus cannot hang.

---
 rtl/apb_slave_router.sv | 174 +++++++++++++++++
 tb/tb_apb_slave_router.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/apb_slave_router.sv
// APB4 single-master to NUM_SLAVES router. It decodes a fixed address-index field and
// answers unmapped addresses and hung slaves with router-generated error responses.
module apb_slave_router #(
  parameter int ADDR_WIDTH     = 32,
  parameter int DATA_WIDTH     = 32,
  parameter int NUM_SLAVES     = 4,
  parameter int IDX_LSB        = 12,
  parameter int IDX_WIDTH      = 2,
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic                             m_psel,
  input  logic                             m_penable,
  input  logic [ADDR_WIDTH-1:0]            m_paddr,
  input  logic [2:0]                       m_pprot,
  input  logic                             m_pwrite,
  input  logic [DATA_WIDTH-1:0]            m_pwdata,
  input  logic [DATA_WIDTH/8-1:0]          m_pstrb,
  output logic                             m_pready,
  output logic [DATA_WIDTH-1:0]            m_prdata,
  output logic                             m_pslverr,
  output logic [NUM_SLAVES-1:0]            s_psel,
  output logic                             s_penable,
  output logic [ADDR_WIDTH-1:0]            s_paddr,
  output logic [2:0]                       s_pprot,
  output logic                             s_pwrite,
  output logic [DATA_WIDTH-1:0]            s_pwdata,
  output logic [DATA_WIDTH/8-1:0]          s_pstrb,
  input  logic [NUM_SLAVES-1:0]            s_pready,
  input  logic [NUM_SLAVES*DATA_WIDTH-1:0] s_prdata,
  input  logic [NUM_SLAVES-1:0]            s_pslverr,
  output logic                             err_valid,
  output logic [1:0]                       err_code,
  output logic [ADDR_WIDTH-1:0]            err_addr
);

  localparam int CNT_W = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;

  typedef enum logic [1:0] {IDLE, ACCESS, DERR} state_e;

  state_e                state_q, state_d;
  logic [IDX_WIDTH-1:0]  sel_q, sel_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [ADDR_WIDTH-1:0] daddr_q, daddr_d;
  logic [ADDR_WIDTH-1:0] err_addr_q, err_addr_d;
  logic [1:0]            err_code_q, err_code_d;

  logic [IDX_WIDTH-1:0]  idx;
  logic                  idx_ok;
  logic                  timeout_hit;
  logic                  sel_ready;
  logic                  sel_err;
  logic [DATA_WIDTH-1:0] sel_rdata;

  assign s_paddr  = m_paddr;
  assign s_pprot  = m_pprot;
  assign s_pwrite = m_pwrite;
  assign s_pwdata = m_pwdata;
  assign s_pstrb  = m_pstrb;

  assign err_code = err_code_q;
  assign err_addr = err_addr_q;

  assign idx         = m_paddr[IDX_LSB +: IDX_WIDTH];
  assign idx_ok      = ({1'b0, idx} < (IDX_WIDTH + 1)'(NUM_SLAVES));
  // With the timeout disabled the counter stays at 0 and this term is masked off.
  assign timeout_hit = (TIMEOUT_CYCLES > 0) && (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));

  always_comb begin
    sel_ready = 1'b0;
    sel_err   = 1'b0;
    sel_rdata = '0;
    for (int i = 0; i < NUM_SLAVES; i++) begin
      if (sel_q == IDX_WIDTH'(i)) begin
        sel_ready = s_pready[i];
        sel_err   = s_pslverr[i];
        sel_rdata = s_prdata[i*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  always_comb begin
    state_d    = state_q;
    sel_d      = sel_q;
    cnt_d      = cnt_q;
    daddr_d    = daddr_q;
    err_addr_d = err_addr_q;
    err_code_d = err_code_q;
    s_psel     = '0;
    s_penable  = 1'b0;
    m_pready   = 1'b0;
    m_prdata   = '0;
    m_pslverr  = 1'b0;
    err_valid  = 1'b0;
    case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (m_psel) begin
          if (idx_ok) begin
            for (int i = 0; i < NUM_SLAVES; i++) s_psel[i] = (idx == IDX_WIDTH'(i));
            sel_d   = idx;
            state_d = ACCESS;
          end else begin
            daddr_d = m_paddr;
            state_d = DERR;
          end
        end
      end
      ACCESS: begin
        for (int i = 0; i < NUM_SLAVES; i++) s_psel[i] = (sel_q == IDX_WIDTH'(i));
        s_penable = m_penable;
        if (m_penable) begin
          if (sel_ready) begin
            m_pready  = 1'b1;
            m_prdata  = sel_rdata;
            m_pslverr = sel_err;
            cnt_d     = '0;
            state_d   = IDLE;
          end else if (timeout_hit) begin
            m_pready   = 1'b1;
            m_pslverr  = 1'b1;
            err_valid  = 1'b1;
            err_code_d = 2'b10;
            err_addr_d = m_paddr;
            cnt_d      = '0;
            state_d    = IDLE;
          end else if (TIMEOUT_CYCLES > 0) begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      DERR: begin
        if (m_penable) begin
          m_pready   = 1'b1;
          m_pslverr  = 1'b1;
          err_valid  = 1'b1;
          err_code_d = 2'b01;
          err_addr_d = daddr_q;
          state_d    = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    // The IDLE pass-through select would otherwise follow m_psel while reset is held.
    if (!rst_n) begin
      s_psel    = '0;
      s_penable = 1'b0;
      m_pready  = 1'b0;
      m_prdata  = '0;
      m_pslverr = 1'b0;
      err_valid = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      sel_q      <= '0;
      cnt_q      <= '0;
      daddr_q    <= '0;
      err_addr_q <= '0;
      err_code_q <= 2'b00;
    end else begin
      state_q    <= state_d;
      sel_q      <= sel_d;
      cnt_q      <= cnt_d;
      daddr_q    <= daddr_d;
      err_addr_q <= err_addr_d;
      err_code_q <= err_code_d;
    end
  end

endmodule

// File: tb/tb_apb_slave_router.sv
// Bench for apb_slave_router with 3 slaves and a 4-cycle timeout. The driver queues the
// model's expected response and a negedge monitor checks each completion against it.
module tb_apb_slave_router;

  localparam int AW    = 32;
  localparam int DW    = 32;
  localparam int SW    = DW / 8;
  localparam int NS    = 3;
  localparam int TO    = 4;
  localparam int NEVER = 255;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic          m_psel, m_penable, m_pwrite;
  logic [AW-1:0] m_paddr;
  logic [2:0]    m_pprot;
  logic [DW-1:0] m_pwdata;
  logic [SW-1:0] m_pstrb;
  logic          m_pready, m_pslverr;
  logic [DW-1:0] m_prdata;
  logic [NS-1:0] s_psel;
  logic          s_penable, s_pwrite;
  logic [AW-1:0] s_paddr;
  logic [2:0]    s_pprot;
  logic [DW-1:0] s_pwdata;
  logic [SW-1:0] s_pstrb;
  logic [NS-1:0] s_pready, s_pslverr;
  logic [NS*DW-1:0] s_prdata;
  logic          err_valid;
  logic [1:0]    err_code;
  logic [AW-1:0] err_addr;

  apb_slave_router #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .NUM_SLAVES(NS),
    .IDX_LSB(12), .IDX_WIDTH(2), .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .m_psel(m_psel), .m_penable(m_penable), .m_paddr(m_paddr), .m_pprot(m_pprot),
    .m_pwrite(m_pwrite), .m_pwdata(m_pwdata), .m_pstrb(m_pstrb),
    .m_pready(m_pready), .m_prdata(m_prdata), .m_pslverr(m_pslverr),
    .s_psel(s_psel), .s_penable(s_penable), .s_paddr(s_paddr), .s_pprot(s_pprot),
    .s_pwrite(s_pwrite), .s_pwdata(s_pwdata), .s_pstrb(s_pstrb),
    .s_pready(s_pready), .s_prdata(s_prdata), .s_pslverr(s_pslverr),
    .err_valid(err_valid), .err_code(err_code), .err_addr(err_addr)
  );

  // Slave models: each answers after w_cfg penable cycles with fixed data/error.
  int unsigned   w_cfg[NS];
  logic [DW-1:0] d_cfg[NS];
  logic          e_cfg[NS];
  int unsigned   scnt[NS];

  always @(posedge clk) begin
    for (int i = 0; i < NS; i++) begin
      if (s_psel[i] && s_penable) scnt[i] <= scnt[i] + 1;
      else                        scnt[i] <= 0;
    end
  end

  always_comb begin
    s_pready  = '0;
    s_pslverr = '0;
    s_prdata  = '0;
    for (int i = 0; i < NS; i++) begin
      s_pready[i]          = (scnt[i] == w_cfg[i]);
      s_pslverr[i]         = e_cfg[i];
      s_prdata[i*DW +: DW] = d_cfg[i];
    end
  end

  typedef struct {
    logic [DW-1:0] rdata;
    logic          slverr;
    logic          errv;
    logic [1:0]    code;
    logic [AW-1:0] eaddr;
    int            cycles;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
  } exp_t;

  exp_t          exp_q[$];
  logic [NS-1:0] exp_sel = '0;
  logic [1:0]    last_code = 2'b00;
  logic [AW-1:0] last_addr = '0;
  int            n_pass = 0;
  int            n_total = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    n_total++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, req, $time);
  endtask

  // Reference: slave index from the address field, then error/timeout/normal rules.
  function automatic exp_t model(input logic [AW-1:0] addr, input logic [DW-1:0] wd,
                                 input int unsigned w, input logic [DW-1:0] d, input logic e);
    exp_t r;
    int   idx = int'((addr >> 12) % 4);
    r.addr  = addr;
    r.wdata = wd;
    if (idx >= NS) begin
      r.rdata = '0; r.slverr = 1'b1; r.errv = 1'b1; r.cycles = 1;
      last_code = 2'b01; last_addr = addr;
    end else if (w >= TO) begin
      r.rdata = '0; r.slverr = 1'b1; r.errv = 1'b1; r.cycles = TO;
      last_code = 2'b10; last_addr = addr;
    end else begin
      r.rdata = d; r.slverr = e; r.errv = 1'b0; r.cycles = int'(w) + 1;
    end
    r.code  = last_code;
    r.eaddr = last_addr;
    return r;
  endfunction

  task automatic xfer(input logic [AW-1:0] addr, input logic wr, input logic [DW-1:0] wd,
                      input int unsigned w, input logic [DW-1:0] d, input logic e, input bit b2b);
    int idx = int'((addr >> 12) % 4);
    bit done = 0;
    if (idx < NS) begin
      w_cfg[idx] = w; d_cfg[idx] = d; e_cfg[idx] = e;
    end
    exp_q.push_back(model(addr, wd, w, d, e));
    m_psel = 1'b1; m_penable = 1'b0; m_paddr = addr; m_pwrite = wr; m_pwdata = wd;
    m_pstrb = SW'($urandom); m_pprot = 3'($urandom);
    exp_sel = '0;
    if (idx < NS) exp_sel[idx] = 1'b1;
    @(posedge clk); #1;
    m_penable = 1'b1;
    for (int k = 0; k < 16 && !done; k++) begin
      @(negedge clk);
      if (m_pready) done = 1;
      @(posedge clk); #1;
    end
    if (!done) chk("pready_wait_bound", 64'd0, 64'd1);
    m_penable = 1'b0;
    if (!b2b) begin
      m_psel = 1'b0; exp_sel = '0;
    end
  endtask

  // Monitor: per-cycle select checks, completion checks, registered error fields next cycle.
  initial begin
    int   pe_cnt = 0;
    bit   chk_code = 0;
    exp_t pend;
    exp_t e;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        pe_cnt = 0; chk_code = 0;
      end else begin
        chk("s_psel", 64'(s_psel), 64'(exp_sel));
        chk("s_penable", 64'(s_penable), 64'(m_penable && (exp_sel != '0)));
        if (chk_code) begin
          chk("err_code", 64'(err_code), 64'(pend.code));
          chk("err_addr", 64'(err_addr), 64'(pend.eaddr));
          chk_code = 0;
        end
        if (m_psel && m_penable) pe_cnt++;
        if (m_pready) begin
          if (exp_q.size() == 0) begin
            chk("unexpected_pready", 64'd1, 64'd0);
          end else begin
            e = exp_q.pop_front();
            chk("m_prdata", 64'(m_prdata), 64'(e.rdata));
            chk("m_pslverr", 64'(m_pslverr), 64'(e.slverr));
            chk("err_valid", 64'(err_valid), 64'(e.errv));
            chk("access_cycles", 64'(pe_cnt), 64'(e.cycles));
            chk("s_paddr", 64'(s_paddr), 64'(e.addr));
            chk("s_pwdata", 64'(s_pwdata), 64'(e.wdata));
            pend = e;
            chk_code = 1;
          end
          pe_cnt = 0;
        end else begin
          chk("err_valid_idle", 64'(err_valid), 64'd0);
        end
      end
    end
  end

  task automatic chk_all_zero(input string tag);
    chk({tag, "_s_psel"}, 64'(s_psel), 64'd0);
    chk({tag, "_s_penable"}, 64'(s_penable), 64'd0);
    chk({tag, "_m_pready"}, 64'(m_pready), 64'd0);
    chk({tag, "_m_prdata"}, 64'(m_prdata), 64'd0);
    chk({tag, "_m_pslverr"}, 64'(m_pslverr), 64'd0);
    chk({tag, "_err_valid"}, 64'(err_valid), 64'd0);
    chk({tag, "_err_code"}, 64'(err_code), 64'd0);
    chk({tag, "_err_addr"}, 64'(err_addr), 64'd0);
  endtask

  initial begin
    int unsigned w;
    bit          b2b;
    m_psel = 0; m_penable = 0; m_paddr = '0; m_pprot = '0; m_pwrite = 0;
    m_pwdata = '0; m_pstrb = '0;
    for (int i = 0; i < NS; i++) begin
      w_cfg[i] = 0; d_cfg[i] = '0; e_cfg[i] = 1'b0;
    end
    repeat (3) @(posedge clk);
    #1;
    m_psel = 1'b1; m_paddr = 32'h0000_1000;
    #1;
    chk_all_zero("reset");
    m_psel = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    xfer(32'h0000_2004, 1'b1, 32'hDEAD_BEEF, 1, 32'hA5A5_0002, 1'b0, 0);
    xfer(32'h0000_1000, 1'b0, 32'h0, 0, 32'h1234_5678, 1'b1, 0);
    xfer(32'h0000_3000, 1'b0, 32'h0, 0, 32'h0, 1'b0, 0);
    @(posedge clk); #1;
    xfer(32'h0000_0000, 1'b0, 32'h0, NEVER, 32'hFFFF_0000, 1'b0, 0);
    xfer(32'h0000_0008, 1'b0, 32'h0, 3, 32'h0BAD_CAFE, 1'b0, 0);
    xfer(32'h0000_0040, 1'b0, 32'h0, 0, 32'h1111_0000, 1'b0, 1);
    xfer(32'h0000_2080, 1'b1, 32'hCAFE_F00D, 0, 32'h2222_0002, 1'b0, 0);

    // Reset asserted while slave 0 is stalling in the access phase.
    w_cfg[0] = NEVER;
    m_psel = 1'b1; m_penable = 1'b0; m_paddr = 32'h0000_0010; m_pwrite = 1'b0;
    exp_sel = 3'b001;
    @(posedge clk); #1;
    m_penable = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    chk_all_zero("midreset");
    last_code = 2'b00; last_addr = '0;
    @(posedge clk); #1;
    m_psel = 1'b0; m_penable = 1'b0; exp_sel = '0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    xfer(32'h0000_1234, 1'b0, 32'h0, 1, 32'h5555_AAAA, 1'b0, 0);

    for (int n = 0; n < 40; n++) begin
      w   = $urandom_range(0, 4);
      if (w == 4) w = NEVER;
      b2b = (n < 39) ? 1'($urandom_range(0, 1)) : 1'b0;
      xfer($urandom, 1'($urandom), $urandom, w, $urandom, 1'($urandom), b2b);
      if (!b2b) repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
    end

    repeat (3) @(posedge clk);
    #1;
    chk("exp_q_drained", 64'(exp_q.size()), 64'd0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
